mul_iter_booth: RTL



---
 rtl/mul_defs.sv | 39 +++
 rtl/booth_r4_sel.sv | 31 +++
 rtl/mul_iter_booth.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mul_defs.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
// Holds the FSM state encoding, the Booth digit encoding (one-hot
// magnitude flags plus a sign flag), the default operand width and the
// triplet-to-digit decoder used by the partial-product selector.
package mul_defs;

  localparam int MUL_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // one/two are one-hot magnitude selects (both clear = digit 0);
  // neg requests the negated multiple.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
  // 111 is encoded as plain zero (neg clear) so that a zero digit never
  // injects a carry-in.
  function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
    booth_digit_t d;
    d = '0;
    case (triplet)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector (combinational).
// Ports:
//   triplet - {b[2i+1], b[2i], b[2i-1]} of the extended multiplier
//   mcand   - multiplicand already extended to WIDTH+2 bits
//   pp      - WIDTH+3 bit selected multiple (one's complement if negative)
//   cin     - carry-in that completes the two's-complement negation
module booth_r4_sel
  import mul_defs::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+2:0] pp,
  output logic             cin
);

  booth_digit_t     dig;
  logic [WIDTH+2:0] mag;

  always_comb begin
    dig = booth_decode(triplet);
    mag = '0;
    if (dig.one)      mag = {mcand[WIDTH+1], mcand};
    else if (dig.two) mag = {mcand, 1'b0};
    // -x = ~x + 1; the +1 rides in as the adder carry-in.
    pp  = dig.neg ? ~mag : mag;
    cin = dig.neg;
  end

endmodule

// File: rtl/mul_iter_booth.sv
// Multi-cycle radix-4 Booth multiplier, signed or unsigned per operation.
// Accepts A/B/in_signed on a valid/ready handshake in IDLE, iterates
// N = WIDTH/2+1 cycles retiring two multiplier bits each, then presents
// the full 2*WIDTH product on Res until the consumer takes it.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   flush            - synchronous cancel of any operation in flight
//   in_valid/ready   - operand handshake (ready only in IDLE)
//   in_signed        - 1: two's-complement operands, 0: unsigned
//   A, B             - multiplicand, multiplier
//   out_valid/ready  - result handshake
//   Res              - full-width product
// WIDTH must be even and at least 4.
module mul_iter_booth
  import mul_defs::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Res
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);
  localparam int XW = WIDTH + 2;  // extended operand width
  localparam int PW = WIDTH + 3;  // accumulator upper half / partial product

  mul_state_e     state;
  logic [CW-1:0]  cnt;
  logic [XW-1:0]  mcand;
  // {acc_hi, acc_lo} is one shift register: acc_lo starts as the extended
  // multiplier and is replaced by low product bits as it shifts right.
  logic [PW-1:0]  acc_hi;
  logic [XW-1:0]  acc_lo;
  logic           acc_m1;   // implicit bit below the multiplier LSB

  logic [PW-1:0]    pp;
  logic             cin;
  logic [PW-1:0]    p_sum;
  logic [PW+XW-1:0] step_nxt;

  booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
    .triplet ({acc_lo[1:0], acc_m1}),
    .mcand   (mcand),
    .pp      (pp),
    .cin     (cin)
  );

  always_comb begin
    p_sum    = acc_hi + pp + PW'(cin);
    step_nxt = $signed({p_sum, acc_lo}) >>> 2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MUL_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Res       <= '0;
      cnt       <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      acc_m1    <= 1'b0;
    end else if (flush) begin
      // Accumulator is left as-is; it is reloaded on the next accept.
      state     <= MUL_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (in_valid) begin
            state    <= MUL_BUSY;
            in_ready <= 1'b0;
            cnt      <= '0;
            mcand    <= {{2{in_signed & A[WIDTH-1]}}, A};
            acc_lo   <= {{2{in_signed & B[WIDTH-1]}}, B};
            acc_hi   <= '0;
            acc_m1   <= 1'b0;
          end
        end
        MUL_BUSY: begin
          {acc_hi, acc_lo} <= step_nxt;
          acc_m1           <= acc_lo[1];
          cnt              <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state     <= MUL_DONE;
            out_valid <= 1'b1;
            Res       <= step_nxt[2*WIDTH-1:0];
            cnt       <= '0;
          end
        end
        MUL_DONE: begin
          if (out_ready) begin
            state     <= MUL_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= MUL_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
